fft_peak_detect: RTL and testbench

- Downstream of the FFT stage in the phase-extraction chain.
- Consumes NSINK consecutive FFT frames, one per antenna, in antenna order. Each frame is 2^FFT complex bins, delimited by sop and eop.
- Finds the strongest positive-frequency bin in antenna 0's frame, then captures the complex value at that same bin from every other antenna.
- Emits one NSINK-entry packet per run for the cartesian-to-polar stage.

---
 rtl/fft_peak_detect.sv | 178 +++++++++++++++++
 tb/tb_fft_peak_detect.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_detect.sv
// Peak-bin detector after the FFT stage: finds the strongest positive-frequency
// bin of antenna 0 and reports the complex sample at that bin for every antenna.
module fft_peak_detect #(
    parameter int NSINK  = 3,
    parameter int WIDTH  = 25,
    parameter int FFT    = 11,
    parameter int MINBIN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sink_valid,
    input  logic             sink_sop,
    input  logic             sink_eop,
    input  logic [WIDTH-1:0] sink_re,
    input  logic [WIDTH-1:0] sink_im,
    output logic             source_valid,
    output logic             source_sop,
    output logic             source_eop,
    output logic [FFT-1:0]   source_bin,
    output logic [WIDTH-1:0] source_re,
    output logic [WIDTH-1:0] source_im,
    output logic             error
);
    localparam int FW = (NSINK > 1) ? $clog2(NSINK) : 1;
    localparam logic [FFT-1:0] BIN_ONE    = FFT'(1);
    localparam logic [FFT-1:0] BIN_LAST   = {FFT{1'b1}};
    localparam logic [FFT-1:0] WIN_LO     = FFT'(MINBIN);
    localparam logic [FFT-1:0] WIN_HI     = FFT'((1 << (FFT - 1)) - 1);
    localparam logic [FW-1:0]  FRAME_ONE  = FW'(1);
    localparam logic [FW-1:0]  LAST_FRAME = FW'(NSINK - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, CAPTURE, EMIT} state_t;

    state_t               state, state_n;
    logic [FFT-1:0]       bin_cnt, bin_cnt_n, cur_bin, peak_bin;
    logic [FW-1:0]        frame_cnt, frame_n, eff_frame, emit_cnt, emit_n;
    logic                 err_n, err_r, accept, restart, search_beat, capture_beat;

    logic signed [2*WIDTH-1:0] re_ext, im_ext, re_sq, im_sq;
    logic [2*WIDTH-1:0]   metric, p_metric, max_metric;
    logic                 p_valid;
    logic [FFT-1:0]       p_bin;
    logic [WIDTH-1:0]     p_re, p_im;
    logic [WIDTH-1:0]     cap_re [NSINK];
    logic [WIDTH-1:0]     cap_im [NSINK];

    assign cur_bin = sink_sop ? '0 : bin_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bin_cnt   <= '0;
            frame_cnt <= '0;
            emit_cnt  <= '0;
            err_r     <= 1'b0;
        end else begin
            state     <= state_n;
            bin_cnt   <= bin_cnt_n;
            frame_cnt <= frame_n;
            emit_cnt  <= emit_n;
            err_r     <= err_n;
        end
    end

    // A beat with bin_cnt == 0 and no sop in CAPTURE sits between frames and is dropped.
    always_comb begin
        state_n      = state;
        bin_cnt_n    = bin_cnt;
        frame_n      = frame_cnt;
        emit_n       = emit_cnt;
        eff_frame    = frame_cnt;
        err_n        = 1'b0;
        accept       = 1'b0;
        restart      = 1'b0;
        search_beat  = 1'b0;
        capture_beat = 1'b0;
        case (state)
            IDLE: begin
                if (sink_valid && sink_sop) begin
                    accept  = 1'b1;
                    restart = 1'b1;
                end
            end
            SEARCH, CAPTURE: begin
                if (sink_valid) begin
                    if (sink_sop && (bin_cnt != '0)) begin
                        err_n   = 1'b1;
                        accept  = 1'b1;
                        restart = 1'b1;
                    end else if (sink_sop || (bin_cnt != '0)) begin
                        accept = 1'b1;
                    end
                end
            end
            EMIT: begin
                emit_n = emit_cnt + FRAME_ONE;
                if (emit_cnt == LAST_FRAME) begin
                    state_n = IDLE;
                    emit_n  = '0;
                end
                if (sink_valid && sink_sop) err_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (accept) begin
            if (restart) begin
                state_n   = SEARCH;
                frame_n   = '0;
                eff_frame = '0;
            end
            bin_cnt_n    = cur_bin + BIN_ONE;
            search_beat  = !restart && (state == SEARCH) && (cur_bin >= WIN_LO) && (cur_bin <= WIN_HI);
            capture_beat = !restart && (state == CAPTURE) && (cur_bin == peak_bin);
            if (sink_eop != (cur_bin == BIN_LAST)) begin
                err_n     = 1'b1;
                state_n   = IDLE;
                bin_cnt_n = '0;
            end else if (sink_eop) begin
                bin_cnt_n = '0;
                if (eff_frame == LAST_FRAME) begin
                    state_n = EMIT;
                    emit_n  = '0;
                end else begin
                    state_n = CAPTURE;
                    frame_n = eff_frame + FRAME_ONE;
                end
            end
        end
    end

    // Sign-extend before squaring so the most negative input cannot overflow.
    assign re_ext = {{WIDTH{sink_re[WIDTH-1]}}, sink_re};
    assign im_ext = {{WIDTH{sink_im[WIDTH-1]}}, sink_im};
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;
    assign metric = $unsigned(re_sq) + $unsigned(im_sq);

    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid    <= 1'b0;
            p_metric   <= '0;
            p_bin      <= '0;
            p_re       <= '0;
            p_im       <= '0;
            max_metric <= '0;
            peak_bin   <= '0;
            for (int i = 0; i < NSINK; i++) begin
                cap_re[i] <= '0;
                cap_im[i] <= '0;
            end
        end else begin
            p_valid  <= search_beat;
            p_metric <= metric;
            p_bin    <= cur_bin;
            p_re     <= sink_re;
            p_im     <= sink_im;
            if (p_valid && ((p_bin == WIN_LO) || (p_metric > max_metric))) begin
                max_metric <= p_metric;
                peak_bin   <= p_bin;
                cap_re[0]  <= p_re;
                cap_im[0]  <= p_im;
            end
            if (capture_beat) begin
                cap_re[frame_cnt] <= sink_re;
                cap_im[frame_cnt] <= sink_im;
            end
        end
    end

    assign source_valid = (state == EMIT);
    assign source_sop   = source_valid && (emit_cnt == '0);
    assign source_eop   = source_valid && (emit_cnt == LAST_FRAME);
    assign source_bin   = source_valid ? peak_bin : '0;
    assign source_re    = source_valid ? cap_re[emit_cnt] : '0;
    assign source_im    = source_valid ? cap_im[emit_cnt] : '0;
    assign error        = err_r;
endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect with NSINK=3, WIDTH=8, FFT=4, MINBIN=1.
module tb_fft_peak_detect;
    localparam int NSINK  = 3;
    localparam int WIDTH  = 8;
    localparam int FFT    = 4;
    localparam int MINBIN = 1;
    localparam int LENGTH = 1 << FFT;

    logic             clk = 1'b0;
    logic             reset;
    logic             sink_valid, sink_sop, sink_eop;
    logic [WIDTH-1:0] sink_re, sink_im;
    logic             source_valid, source_sop, source_eop, error;
    logic [FFT-1:0]   source_bin;
    logic [WIDTH-1:0] source_re, source_im;

    int vectors = 0;
    int miscompares = 0;
    int errCount = 0;
    int validCount = 0;
    int baseErr, baseValid;
    int fre [NSINK][LENGTH];
    int fim [NSINK][LENGTH];
    int expBin;
    int er [NSINK];
    int ei [NSINK];

    fft_peak_detect #(.NSINK(NSINK), .WIDTH(WIDTH), .FFT(FFT), .MINBIN(MINBIN)) dut (
        .clk(clk), .reset(reset),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_re(sink_re), .sink_im(sink_im),
        .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
        .source_bin(source_bin), .source_re(source_re), .source_im(source_im),
        .error(error)
    );

    always #5 clk = ~clk;

    // Running tallies of error pulses and output-valid cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (error === 1'b1) errCount++;
        if (source_valid === 1'b1) validCount++;
    end

    task automatic applyStimulus(input logic v, input logic s, input logic e, input int re, input int im);
        sink_valid = v;
        sink_sop   = s;
        sink_eop   = e;
        sink_re    = re[WIDTH-1:0];
        sink_im    = im[WIDTH-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] observed, input logic signed [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic clearData();
        for (int f = 0; f < NSINK; f++)
            for (int b = 0; b < LENGTH; b++) begin
                fre[f][b] = 0;
                fim[f][b] = 0;
            end
    endtask

    task automatic sendFrame(input int f, input int nbeats, input int eopBin);
        for (int b = 0; b < nbeats; b++)
            applyStimulus(1'b1, b == 0, b == eopBin, fre[f][b], fim[f][b]);
    endtask

    task automatic sendRun();
        for (int f = 0; f < NSINK; f++) sendFrame(f, LENGTH, LENGTH - 1);
    endtask

    // Entry 0 is already visible when the last eop beat has been applied.
    task automatic checkPacket(input string tag);
        for (int k = 0; k < NSINK; k++) begin
            checkOutput($sformatf("%s_e%0d_valid", tag, k), source_valid, 1);
            checkOutput($sformatf("%s_e%0d_sop", tag, k), source_sop, k == 0);
            checkOutput($sformatf("%s_e%0d_eop", tag, k), source_eop, k == NSINK - 1);
            checkOutput($sformatf("%s_e%0d_bin", tag, k), source_bin, expBin);
            checkOutput($sformatf("%s_e%0d_re", tag, k), $signed(source_re), er[k]);
            checkOutput($sformatf("%s_e%0d_im", tag, k), $signed(source_im), ei[k]);
            idle();
        end
        checkOutput({tag, "_valid_after"}, source_valid, 0);
        checkOutput({tag, "_bin_after"}, source_bin, 0);
        checkOutput({tag, "_re_after"}, $signed(source_re), 0);
    endtask

    task automatic loadCase1();
        clearData();
        for (int b = 0; b < LENGTH; b++) begin
            fre[0][b] = 1;
            fim[0][b] = 1;
        end
        fre[0][5] = 100; fim[0][5] = -50;
        fre[1][5] = 3;   fim[1][5] = 4;
        fre[2][5] = -7;  fim[2][5] = 0;
        expBin = 5;
        er = '{100, 3, -7};
        ei = '{-50, 4, 0};
    endtask

    task automatic loadCase2();
        clearData();
        fre[0][0] = 127; fim[0][0] = 127;
        fre[0][12] = 120;
        fre[0][3] = 60;
        fre[0][6] = 60;
        fre[1][3] = 10;  fim[1][3] = -10;
        fre[2][3] = -1;  fim[2][3] = 5;
        expBin = 3;
        er = '{60, 10, -1};
        ei = '{0, -10, 5};
    endtask

    initial begin
        reset = 1'b1;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        sink_re = '0; sink_im = '0;
        idle();
        idle();
        checkOutput("rst_valid", source_valid, 0);
        checkOutput("rst_sop", source_sop, 0);
        checkOutput("rst_eop", source_eop, 0);
        checkOutput("rst_bin", source_bin, 0);
        checkOutput("rst_re", $signed(source_re), 0);
        checkOutput("rst_im", $signed(source_im), 0);
        checkOutput("rst_error", error, 0);
        reset = 1'b0;
        idle();

        $display("[TB] basic run, peak at bin 5");
        loadCase1();
        baseErr = errCount;
        sendRun();
        checkPacket("t1");
        checkOutput("t1_no_error", errCount - baseErr, 0);

        $display("[TB] DC and negative bins excluded, tie keeps lowest bin");
        loadCase2();
        sendRun();
        checkPacket("t2");

        $display("[TB] full-scale metric at last window bin");
        clearData();
        fre[0][7] = -128; fim[0][7] = -128;
        fre[0][2] = 127;  fim[0][2] = 127;
        fre[1][7] = 5;    fim[1][7] = 6;
        fre[2][7] = 7;    fim[2][7] = 8;
        expBin = 7;
        er = '{-128, 5, 7};
        ei = '{-128, 6, 8};
        sendRun();
        checkPacket("t3");

        $display("[TB] early eop in frame 1");
        loadCase1();
        baseValid = validCount;
        sendFrame(0, LENGTH, LENGTH - 1);
        sendFrame(1, 10, 9);
        checkOutput("t4_err_pulse", error, 1);
        idle();
        checkOutput("t4_err_clear", error, 0);
        repeat (4) idle();
        checkOutput("t4_no_packet", validCount - baseValid, 0);
        sendRun();
        checkPacket("t4_next");

        $display("[TB] missing eop at last bin");
        sendFrame(0, LENGTH, -1);
        checkOutput("t4b_err_pulse", error, 1);
        idle();
        checkOutput("t4b_valid", source_valid, 0);

        $display("[TB] reset mid-run and during output");
        loadCase1();
        baseValid = validCount;
        sendFrame(0, LENGTH, LENGTH - 1);
        sendFrame(1, 7, -1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        checkOutput("t5_valid", source_valid, 0);
        checkOutput("t5_error", error, 0);
        repeat (3) idle();
        checkOutput("t5_no_packet", validCount - baseValid, 0);
        sendRun();
        checkOutput("t5_emit_valid", source_valid, 1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        checkOutput("t5_emit_rst_valid", source_valid, 0);
        checkOutput("t5_emit_rst_sop", source_sop, 0);
        checkOutput("t5_emit_rst_bin", source_bin, 0);
        checkOutput("t5_emit_rst_re", $signed(source_re), 0);
        checkOutput("t5_emit_rst_im", $signed(source_im), 0);
        loadCase2();
        sendRun();
        checkPacket("t5_next");

        $display("[TB] peak at lowest window bin, all-zero search frame");
        clearData();
        fre[0][1] = 50; fim[0][1] = 50;
        fre[0][9] = 127;
        fre[1][1] = -9; fim[1][1] = 2;
        fre[2][1] = 4;  fim[2][1] = -4;
        expBin = 1;
        er = '{50, -9, 4};
        ei = '{50, 2, -4};
        sendRun();
        checkPacket("t6a");
        clearData();
        fre[1][1] = 11; fim[1][1] = 12;
        fre[1][2] = 99;
        fre[2][1] = 13; fim[2][1] = 14;
        expBin = 1;
        er = '{0, 11, 13};
        ei = '{0, 12, 14};
        sendRun();
        checkPacket("t6b");

        $display("[TB] sop in the middle of a frame restarts the run");
        loadCase2();
        baseErr = errCount;
        sendFrame(0, 5, -1);
        sendRun();
        checkPacket("t7");
        checkOutput("t7_err_count", errCount - baseErr, 1);

        $display("[TB] sop while emitting");
        loadCase1();
        baseErr = errCount;
        sendRun();
        baseValid = validCount;
        sendFrame(1, LENGTH, LENGTH - 1);
        checkOutput("t8_err_count", errCount - baseErr, 1);
        checkOutput("t8_valid_cycles", validCount - baseValid, NSINK);
        loadCase2();
        sendRun();
        checkPacket("t8_next");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
